seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered successor of the lab 4-function ALU: multiply, compare, add and subtract on WIDTH-bit operands, with carry, signed-overflow, zero and negative flags.
- Operands and opcode are accepted through a valid/ready handshake; results are returned through a second valid/ready handshake.
- Multiply is an iterative shift-add taking WIDTH cycles; other ops complete in one cycle.
- Sits between the lab datapath register file and the result/display stage.

Parameters:
WIDTH, 5, operand and result width in bits (min 2)
CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands/opcode present
in_ready  output  1  block can accept an operation
op  input  2  00 MUL, 01 CMP, 10 ADD, 11 SUB
x  input  WIDTH  operand X
y  input  WIDTH  operand Y
out_valid  output  1  result and flags valid
out_ready  input  1  consumer takes result
f  output  WIDTH  result
cout  output  1  carry / borrow / compare / multiply-high flag
overflow  output  1  two's-complement overflow
zero  output  1  f == 0
negative  output  1  f[WIDTH-1]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; f=0, cout=0, overflow=0, zero=0, negative=0, out_valid=0, counter=0, operand registers=0.
- in_ready is combinational, equal to (state==IDLE).
- Accept: occurs on in_valid && in_ready at a rising edge. x, y and op are latched. Input changes after accept are ignored.
- States: IDLE, MUL, DONE.
  - IDLE, accept, op!=MUL: compute and register the result, go to DONE. out_valid=1 on the next cycle (latency 1).
  - IDLE, accept, op==MUL: clear the 2*WIDTH accumulator, load the counter with WIDTH, go to MUL.
  - MUL: each cycle, if the multiplier LSB is 1 add the shifted multiplicand, shift, decrement the counter. When the counter reaches 1, the final iteration registers the result and goes to DONE. out_valid rises exactly WIDTH cycles after the accept edge.
  - DONE: out_valid=1; f and flags are held stable. On out_ready, go to IDLE, out_valid=0 next cycle.
- No new op is accepted until the result is consumed; throughput is at most 1 op per 2 cycles.
- Arithmetic (all unsigned except overflow):
  - MUL: P = x*y (2*WIDTH bits); f = P[WIDTH-1:0]; cout = |P[2W-1:W]; overflow = 0.
  - CMP: f = 0; cout = (x > y) unsigned; overflow = 0; zero = 1.
  - ADD: {cout,f} = x + y; overflow = (x[W-1]==y[W-1]) && (f[W-1]!=x[W-1]).
  - SUB: f = x - y mod 2^W; cout = borrow = (x < y); overflow = (x[W-1]!=y[W-1]) && (f[W-1]!=x[W-1]).
  - zero and negative are always derived from the final registered f.
- Flags are only meaningful while out_valid=1; they hold their last value otherwise.
- Boundaries:
  - Multiply by 0 still takes WIDTH cycles.
  - x=y=all-ones: ADD gives cout=1; MUL gives cout=1.
  - in_valid held high while busy is ignored and not queued.
  - out_ready asserted outside DONE has no effect.
- Reset mid-operation: immediately aborts the MUL or DONE state, clears outputs, and returns to IDLE. The in-flight result is lost.

Decomposition:
- Package seq_alu_pkg:
  - opcode localparams OP_MUL=2'b00, OP_CMP=2'b01, OP_ADD=2'b10, OP_SUB=2'b11;
  - state encoding S_IDLE, S_MUL, S_DONE.
- One sub-module: seq_alu_mul, the shift-add engine. It has WIDTH parameter, start/busy/done, and a 2*WIDTH product output.
- The top level holds the FSM, handshakes, single-cycle ops and flag generation.

Test Plan (WIDTH=5):
- ADD x=01111, y=00001, out_ready=1 -> 1 cycle later: f=10000, cout=0, overflow=1, negative=1, zero=0.
- SUB x=00011, y=00101 -> f=11110, cout=1, overflow=0, negative=1; SUB x=10000, y=00001 -> f=01111, overflow=1.
- MUL x=7, y=6 -> out_valid rises exactly 5 cycles after accept: f=01010, cout=1, overflow=0; MUL x=3, y=5 -> f=01111, cout=0.
- CMP x=9, y=3 -> f=0, cout=1, zero=1; CMP x=3, y=9 -> cout=0.
- Backpressure: hold out_ready=0 for 4 cycles after ADD 2+3 -> f=00101 stable, in_ready=0, a second in_valid is ignored; out_ready=1 -> IDLE, then the second op is accepted.
- Assert rst 2 cycles into MUL 31*31 -> all outputs 0, in_ready=1 immediately. A subsequent ADD 1+1 then returns f=00010.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package seq_alu_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: WIDTH iterations per product, one per clock.
module seq_alu_mul
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] addend;

  // product_o already includes the current iteration's partial product, so the
  // caller can register the final result on the same edge as the last step.
  always_comb begin
    addend    = mplier_q[0] ? mcand_q : '0;
    product_o = acc_q + addend;
    busy_o    = (cnt_q != '0);
    done_o    = (cnt_q == CNT_W'(1));
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = CNT_W'(WIDTH);
    end else if (busy_o) begin
      acc_d    = product_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered 4-function ALU (MUL/CMP/ADD/SUB) with valid/ready handshakes on
// both sides; multiply is delegated to the iterative shift-add engine.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;

  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               res_load;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  seq_alu_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (x),
    .b_i      (y),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  assign sum  = {1'b0, x} + {1'b0, y};
  assign diff = {1'b0, x} - {1'b0, y};

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    mul_start = 1'b0;
    res_load  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          unique case (op)
            OP_MUL: begin
              mul_start = 1'b1;
              state_d   = S_MUL;
            end
            OP_CMP: begin
              f_d      = '0;
              cout_d   = (x > y);
              ovf_d    = 1'b0;
              res_load = 1'b1;
              state_d  = S_DONE;
            end
            OP_ADD: begin
              f_d      = sum[WIDTH-1:0];
              cout_d   = sum[WIDTH];
              ovf_d    = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
              res_load = 1'b1;
              state_d  = S_DONE;
            end
            default: begin
              f_d      = diff[WIDTH-1:0];
              cout_d   = diff[WIDTH];
              ovf_d    = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
              res_load = 1'b1;
              state_d  = S_DONE;
            end
          endcase
        end
      end
      S_MUL: begin
        if (mul_done) begin
          f_d      = mul_product[WIDTH-1:0];
          cout_d   = |mul_product[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          res_load = 1'b1;
          state_d  = S_DONE;
        end else if (!mul_busy) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // zero/negative track the result only when a new one is registered
    if (res_load) begin
      zero_d = (f_d == '0);
      neg_d  = f_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      f_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign f         = f_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expectations are queued at accept and popped when out_valid rises.
module tb_seq_alu;

  localparam int W = 5;
  localparam logic [1:0] MUL = 2'b00, CMP = 2'b01, ADD = 2'b10, SUB = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] x, y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         cout, overflow, zero, negative;

  typedef struct {
    logic [W-1:0] f;
    logic         c, v, z, n;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input int a, input int b);
    exp_t e;
    int   r, sa, sb_, s;
    int   m = 1 << W;
    sa = (a >= m / 2) ? a - m : a;
    sb_ = (b >= m / 2) ? b - m : b;
    e.v = 1'b0;
    e.lat = 0;
    case (o)
      MUL: begin r = a * b; e.c = (r >= m); r = r % m; e.lat = W; end
      CMP: begin r = 0; e.c = (a > b); end
      ADD: begin r = a + b; e.c = (r >= m); r = r % m; s = sa + sb_;
                 e.v = (s > m / 2 - 1) || (s < -m / 2); end
      default: begin r = (a - b + m) % m; e.c = (a < b); s = sa - sb_;
                 e.v = (s > m / 2 - 1) || (s < -m / 2); end
    endcase
    e.f = W'(r);
    e.z = (r == 0);
    e.n = (r >= m / 2);
    return e;
  endfunction

  task automatic send(input logic [1:0] o, input int a, input int b);
    int n = 0;
    @(negedge clk);
    op = o; x = W'(a); y = W'(b); in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept", in_ready, 1);
    sb.push_back(model(o, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk({tag, "_valid"}, out_valid, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"}, lat, e.lat);
      chk({tag, "_f"}, f, e.f);
      chk({tag, "_cout"}, cout, e.c);
      chk({tag, "_ovf"}, overflow, e.v);
      chk({tag, "_zero"}, zero, e.z);
      chk({tag, "_neg"}, negative, e.n);
    end
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_consumed"}, out_valid, 0);
      chk({tag, "_idle"}, in_ready, 1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; x = '0; y = '0; out_ready = 1'b1;
    #12;
    chk("rst_f", f, 0);
    chk("rst_flags", {cout, overflow, zero, negative}, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;

    send(ADD, 15, 1);  wait_result("add_ovf");
    send(SUB, 3, 5);   wait_result("sub_borrow");
    send(SUB, 16, 1);  wait_result("sub_ovf");
    send(MUL, 7, 6);   wait_result("mul_7x6");
    send(MUL, 3, 5);   wait_result("mul_3x5");
    send(MUL, 0, 23);  wait_result("mul_zero");
    send(MUL, 31, 31); wait_result("mul_max");
    send(ADD, 31, 31); wait_result("add_max");
    send(CMP, 9, 3);   wait_result("cmp_gt");
    send(CMP, 3, 9);   wait_result("cmp_lt");
    send(CMP, 4, 4);   wait_result("cmp_eq");

    // backpressure: result held, second request ignored until consumed
    out_ready = 1'b0;
    send(ADD, 2, 3);   wait_result("bp_first");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op = ADD; x = W'(7); y = W'(7); in_valid = 1'b1;
      chk("bp_hold_f", f, 5);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    send(ADD, 7, 7);   wait_result("bp_second");
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp_not_queued", out_valid, 0);
    end

    // reset in the middle of a multiply
    send(MUL, 31, 31);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("mrst_f", f, 0);
    chk("mrst_flags", {cout, overflow, zero, negative}, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", in_ready, 1);
    void'(sb.pop_back());
    @(negedge clk); rst = 1'b0;
    send(ADD, 1, 1);   wait_result("post_rst_add");
    repeat (W + 2) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", out_valid, 0);
    end

    for (int i = 0; i < 16; i++) begin
      send(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      wait_result("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
